brpred_update_ctrl: RTL and testbench
=====================================

BRPRED_UPDATE_CTRL -- requirements
Module: brpred_update_ctrl

Interface
REQ-001 Parameter NUM_INDEX_BIT, default 3: predictor index width; NUM_ENTRY = 2**NUM_INDEX_BIT.
REQ-002 Parameter FIFO_DEPTH, default 4: resolution buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 res_valid_i  input  1  EX stage presents a resolved branch.
REQ-006 res_ready_o  output  1  controller accepts the resolution this cycle.
REQ-007 res_addr_i  input  32  branch PC.
REQ-008 res_taken_i  input  1  actual branch outcome.
REQ-009 res_miss_i  input  1  the branch was mispredicted.
REQ-010 clear_req_i  input  1  one-cycle request to reinitialise the predictor table.
REQ-011 clear_busy_o  output  1  a table clear is in progress.
REQ-012 upd_valid_o  output  1  update presented to the predictor write port.
REQ-013 upd_ready_i  input  1  predictor accepts the update.
REQ-014 upd_addr_o  output  32  update PC; upd_taken_o and upd_miss_o, each 1 bit, carry the outcome and mispredict flag.
REQ-015 clr_we_o  output  1  clear-write strobe; clr_index_o  output  NUM_INDEX_BIT  entry to reset to weakly-taken.
REQ-016 miss_cnt_o  output  16  count of mispredicted updates delivered.

Function
REQ-017 The FSM SHALL have states S_RUN and S_CLEAR; it SHALL enter S_RUN out of reset.
REQ-018 Push: res_valid_i & res_ready_o stores {addr, taken, miss} at the FIFO tail.
REQ-019 res_ready_o SHALL equal (state==S_RUN) & !full & !clear_req_i (combinational).
REQ-020 upd_valid_o SHALL equal (state==S_RUN) & !empty; upd_* SHALL show the head entry, driven from registers.
REQ-021 Pop: upd_valid_o & upd_ready_i removes the head entry; upd_* SHALL hold stable while upd_valid_o=1 and upd_ready_i=0.
REQ-022 Latency: an entry pushed into an empty FIFO SHALL appear on upd_valid_o in the next cycle; there is no same-cycle bypass.
REQ-023 A push and a pop in the same cycle SHALL leave the occupancy unchanged; when full, res_ready_o=0 even if a pop occurs.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-025 clear_req_i=1 in S_RUN SHALL discard all FIFO entries and move to S_CLEAR on the next edge, with clr_index=0; an in-flight pop in that cycle SHALL still complete.
REQ-026 In S_CLEAR: clr_we_o=1, clear_busy_o=1, and clr_index_o increments each cycle. After the cycle with index NUM_ENTRY-1 the FSM SHALL return to S_RUN, so a clear lasts exactly NUM_ENTRY cycles.
REQ-027 clear_req_i SHALL be ignored in S_CLEAR.
REQ-028 miss_cnt_o SHALL increment on each pop with upd_miss_o=1 and saturate at 0xFFFF; a clear SHALL NOT reset it.
REQ-029 In S_RUN: clr_we_o=0, clear_busy_o=0, and clr_index_o=0.

Reset
REQ-030 Asserting rst_n low SHALL immediately set state=S_RUN, empty the FIFO, and zero pointers, clr_index, and miss_cnt_o.
REQ-031 Under reset: res_ready_o=0, upd_valid_o=0, clr_we_o=0, clear_busy_o=0, and upd_* data=0.
REQ-032 Reset asserted mid-clear SHALL abort the clear; after deassertion the controller is in S_RUN with no clear pending.

Structure
REQ-033 Package brpred_pkg SHALL hold the state encoding, the NUM_INDEX_BIT and FIFO_DEPTH defaults, and the weakly-taken constant (2'd2).
REQ-034 The FIFO SHALL be a sub-module brpred_upd_fifo (parameterised width/depth, push/pop/full/empty/flush); the FSM, the clear walker and the counter SHALL sit in the top module.

Verification
REQ-035 Push 4 resolutions with upd_ready_i=0 -> res_ready_o=0 on the 5th cycle; raise upd_ready_i -> the 4 updates emerge in order on consecutive cycles.
REQ-036 Push while popping when occupancy is 2 for 3 cycles -> occupancy stays 2, no loss, no duplicate.
REQ-037 Pulse clear_req_i with 3 entries queued -> entries discarded; clr_we_o high for exactly 8 cycles with index 0..7; then back to S_RUN with upd_valid_o=0.
REQ-038 Assert clear_req_i and res_valid_i in the same cycle -> res_ready_o=0 and the resolution is not stored.
REQ-039 Preload miss_cnt_o to 0xFFFE via 2 pops with miss=1 -> reads 0xFFFF and stays there.
REQ-040 Drop rst_n at clear index 3, asynchronously mid-cycle -> outputs reach reset values before the next edge; after release, S_RUN and clr_we_o=0.

Source files
------------

// File: rtl/brpred_pkg.sv
`timescale 1ns/1ps
// brpred_pkg: shared definitions for the branch-predictor update controller.
//   - default geometry (predictor index width, resolution buffer depth)
//   - controller state encoding
//   - the packed resolution record buffered between EX and the predictor
//   - the weakly-taken counter value that cleared entries are reset to
package brpred_pkg;

    localparam int DEF_NUM_INDEX_BIT = 3;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int MISS_CNT_W        = 16;

    localparam logic [1:0] WEAKLY_TAKEN = 2'd2;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        taken;
        logic        miss;
    } res_entry_t;

endpackage

// File: rtl/brpred_upd_fifo.sv
`timescale 1ns/1ps
// brpred_upd_fifo: small synchronous FIFO buffering branch resolutions.
//   clk, rst_n         : clock, async active-low reset
//   push, push_data    : write push_data at the tail (caller guarantees !full)
//   pop                : drop the head entry (caller guarantees !empty)
//   flush              : discard every entry; takes priority over push/pop
//   full, empty        : occupancy flags
//   head_data          : current head entry, read straight from storage flops
module brpred_upd_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full (MSBs differ) from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/brpred_update_ctrl.sv
`timescale 1ns/1ps
// brpred_update_ctrl: buffers resolved branches from EX and feeds them to the
// predictor write port; on request walks every table entry back to
// weakly-taken, and counts delivered mispredicted updates.
//   res_valid_i/res_ready_o, res_addr_i, res_taken_i, res_miss_i : resolution in
//   clear_req_i, clear_busy_o                                     : table clear
//   upd_valid_o/upd_ready_i, upd_addr_o, upd_taken_o, upd_miss_o  : update out
//   clr_we_o, clr_index_o                                         : clear writes
//   miss_cnt_o                                                    : saturating
//
// state   | meaning
// S_RUN   | buffer resolutions and deliver updates
// S_CLEAR | one clear write per cycle, index 0 .. NUM_ENTRY-1
module brpred_update_ctrl
    import brpred_pkg::*;
#(
    parameter int NUM_INDEX_BIT = DEF_NUM_INDEX_BIT,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    input  logic [31:0]              res_addr_i,
    input  logic                     res_taken_i,
    input  logic                     res_miss_i,
    input  logic                     clear_req_i,
    output logic                     clear_busy_o,
    output logic                     upd_valid_o,
    input  logic                     upd_ready_i,
    output logic [31:0]              upd_addr_o,
    output logic                     upd_taken_o,
    output logic                     upd_miss_o,
    output logic                     clr_we_o,
    output logic [NUM_INDEX_BIT-1:0] clr_index_o,
    output logic [MISS_CNT_W-1:0]    miss_cnt_o
);

    localparam int NUM_ENTRY = 2 ** NUM_INDEX_BIT;
    localparam logic [NUM_INDEX_BIT-1:0] LAST_INDEX = NUM_INDEX_BIT'(NUM_ENTRY - 1);

    ctrl_state_e              state;
    logic                     clr_active;
    logic [NUM_INDEX_BIT-1:0] clr_index;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     flush;
    res_entry_t               push_entry;
    res_entry_t               head_entry;

    // rst_n gates ready so nothing is accepted while reset is held.
    assign res_ready_o = rst_n && (state == S_RUN) && !fifo_full && !clear_req_i;
    assign upd_valid_o = (state == S_RUN) && !fifo_empty;

    assign push  = res_valid_i && res_ready_o;
    assign pop   = upd_valid_o && upd_ready_i;
    assign flush = (state == S_RUN) && clear_req_i;

    assign push_entry = '{addr: res_addr_i, taken: res_taken_i, miss: res_miss_i};

    brpred_upd_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_entry)
    );

    assign upd_addr_o  = head_entry.addr;
    assign upd_taken_o = head_entry.taken;
    assign upd_miss_o  = head_entry.miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            clr_active <= 1'b0;
            clr_index  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (clear_req_i) begin
                        state      <= S_CLEAR;
                        clr_active <= 1'b1;
                        clr_index  <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_index == LAST_INDEX) begin
                        state      <= S_RUN;
                        clr_active <= 1'b0;
                        clr_index  <= '0;
                    end else begin
                        clr_index <= clr_index + 1'b1;
                    end
                end
                default: begin
                    state      <= S_RUN;
                    clr_active <= 1'b0;
                    clr_index  <= '0;
                end
            endcase
        end
    end

    assign clr_we_o     = clr_active;
    assign clear_busy_o = clr_active;
    assign clr_index_o  = clr_index;

    // A clear deliberately leaves the mispredict count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_o <= '0;
        end else if (pop && upd_miss_o && (miss_cnt_o != {MISS_CNT_W{1'b1}})) begin
            miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_brpred_update_ctrl.sv
`timescale 1ns/1ps
module tb_brpred_update_ctrl;
    import brpred_pkg::*;

    localparam int NIB   = 3;
    localparam int DEPTH = 4;
    localparam int NENT  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           res_valid = 1'b0;
    logic           res_ready;
    logic [31:0]    res_addr = '0;
    logic           res_taken = 1'b0;
    logic           res_miss = 1'b0;
    logic           clear_req = 1'b0;
    logic           clear_busy;
    logic           upd_valid;
    logic           upd_ready = 1'b0;
    logic [31:0]    upd_addr;
    logic           upd_taken;
    logic           upd_miss;
    logic           clr_we;
    logic [NIB-1:0] clr_index;
    logic [15:0]    miss_cnt;

    brpred_update_ctrl #(.NUM_INDEX_BIT(NIB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid_i  (res_valid),
        .res_ready_o  (res_ready),
        .res_addr_i   (res_addr),
        .res_taken_i  (res_taken),
        .res_miss_i   (res_miss),
        .clear_req_i  (clear_req),
        .clear_busy_o (clear_busy),
        .upd_valid_o  (upd_valid),
        .upd_ready_i  (upd_ready),
        .upd_addr_o   (upd_addr),
        .upd_taken_o  (upd_taken),
        .upd_miss_o   (upd_miss),
        .clr_we_o     (clr_we),
        .clr_index_o  (clr_index),
        .miss_cnt_o   (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic        miss;
    } ent_t;

    ent_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          clr_left = 0;
    int          n_pop_obs = 0;
    int          n_we_obs = 0;
    int          guard = 0;
    logic [15:0] miss_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with inputs already driven; samples at posedge+3,
    // advances the reference model, and returns at the next posedge+1.
    task automatic cycle();
        bit   in_clear, exp_ready, exp_uvalid, do_pop, do_push;
        ent_t e;
        #2;
        in_clear   = (clr_left > 0);
        exp_ready  = !in_clear && (sb.size() < DEPTH) && !clear_req;
        exp_uvalid = !in_clear && (sb.size() > 0);
        chk("res_ready", 32'(res_ready), 32'(exp_ready));
        chk("upd_valid", 32'(upd_valid), 32'(exp_uvalid));
        chk("clr_we", 32'(clr_we), 32'(in_clear));
        chk("clear_busy", 32'(clear_busy), 32'(in_clear));
        chk("clr_index", 32'(clr_index), in_clear ? 32'(NENT - clr_left) : 32'd0);
        chk("miss_cnt", 32'(miss_cnt), 32'(miss_exp));
        if (exp_uvalid) begin
            chk("upd_addr", upd_addr, sb[0].addr);
            chk("upd_taken", 32'(upd_taken), 32'(sb[0].taken));
            chk("upd_miss", 32'(upd_miss), 32'(sb[0].miss));
        end
        if (upd_valid && upd_ready) n_pop_obs++;
        if (clr_we) n_we_obs++;
        do_pop  = exp_uvalid && upd_ready;
        do_push = res_valid && exp_ready;
        if (do_pop) begin
            e = sb.pop_front();
            if (e.miss && miss_exp != 16'hFFFF) miss_exp++;
        end
        if (do_push) sb.push_back('{addr: res_addr, taken: res_taken, miss: res_miss});
        if (in_clear) clr_left--;
        else if (clear_req) begin
            sb.delete();
            clr_left = NENT;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        chk("rst_res_ready", 32'(res_ready), 32'd0);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_clr_we", 32'(clr_we), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("rst_upd_addr", upd_addr, 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full with the predictor stalled, then drain in order
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1;
            res_addr  = 32'h0000_1000 + 32'(i * 16);
            res_taken = i[0];
            res_miss  = (i == 1 || i == 2);
            cycle();
        end
        res_addr = 32'hDEAD_0000;
        cycle();
        res_valid = 1'b0;
        upd_ready = 1'b1;
        n_pop_obs = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("t1_pops", 32'(n_pop_obs), 32'd4);
        chk("t1_empty", 32'(upd_valid), 32'd0);

        // Push while popping at occupancy 2
        upd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            res_valid = 1'b1;
            res_addr  = 32'h0000_2000 + 32'(i * 4);
            res_taken = 1'b1;
            res_miss  = i[0];
            cycle();
        end
        upd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_addr  = 32'h0000_3000 + 32'(i * 4);
            res_taken = i[0];
            res_miss  = 1'b0;
            cycle();
        end
        res_valid = 1'b0;
        n_pop_obs = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t2_drain", 32'(n_pop_obs), 32'd2);

        // Clear with 3 queued entries, in-flight pop, ignored re-request
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1;
            res_addr  = 32'h0000_4000 + 32'(i * 4);
            res_taken = 1'b0;
            res_miss  = 1'b1;
            cycle();
        end
        res_valid = 1'b0;
        clear_req = 1'b1;
        upd_ready = 1'b1;
        cycle();
        clear_req = 1'b0;
        n_we_obs  = 0;
        for (int i = 0; i < 4; i++) cycle();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t3_we_cycles", 32'(n_we_obs), 32'd8);
        chk("t3_upd_valid", 32'(upd_valid), 32'd0);
        chk("t3_miss_inflight", 32'(miss_cnt), 32'd4);

        // Clear request and resolution in the same cycle
        res_valid = 1'b1;
        res_addr  = 32'hBEEF_0000;
        clear_req = 1'b1;
        cycle();
        res_valid = 1'b0;
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        chk("t4_not_stored", 32'(upd_valid), 32'd0);

        // Asynchronous reset at clear index 3
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        #2;
        chk("t5_idx_before", 32'(clr_index), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_clr_we", 32'(clr_we), 32'd0);
        chk("t5_clear_busy", 32'(clear_busy), 32'd0);
        chk("t5_clr_index", 32'(clr_index), 32'd0);
        chk("t5_res_ready", 32'(res_ready), 32'd0);
        chk("t5_upd_valid", 32'(upd_valid), 32'd0);
        chk("t5_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("t5_upd_addr", upd_addr, 32'd0);
        sb.delete();
        clr_left = 0;
        miss_exp = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        chk("t5_after_we", 32'(clr_we), 32'd0);

        // Stream mispredicts up to saturation
        res_valid = 1'b1;
        res_miss  = 1'b1;
        upd_ready = 1'b1;
        guard     = 0;
        while (miss_exp != 16'hFFFE && guard < 70000) begin
            res_addr  = $urandom;
            res_taken = 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        chk("t6_fffe", 32'(miss_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            res_addr = $urandom;
            cycle();
        end
        chk("t6_sat", 32'(miss_cnt), 32'h0000_FFFF);
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        chk("t6_after_clear", 32'(miss_cnt), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
